xps2_tx: RTL and testbench

XPS2_TX -- requirements
Module: xps2_tx

---
 rtl/xps2_tx.sv | 199 +++++++++++++++++++
 tb/tb_xps2_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a command byte out on device clock falls and checks the device ACK.
module xps2_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic [2:0] state_dbg
);

   localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_REQ       = 3'd2,
      S_XFER      = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       bit_idx, bit_n;
   logic [7:0]       byte_q, byte_n;
   logic             par_q, par_n;
   logic             clk_oe_q, clk_oe_n;
   logic             data_oe_q, data_oe_n;
   logic             done_q, done_n;
   logic             err_q, err_n;

   logic clk_meta, clk_s, clk_prev;
   logic data_meta, data_s;
   logic fall;

   // Synchronizers idle high, matching a released open-drain bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_meta  <= 1'b1;
         clk_s     <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_s    <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk_in;
         clk_s     <= clk_meta;
         clk_prev  <= clk_s;
         data_meta <= ps2_data_in;
         data_s    <= data_meta;
      end
   end

   assign fall = clk_prev & ~clk_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         byte_q    <= '0;
         par_q     <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_n;
         byte_q    <= byte_n;
         par_q     <= par_n;
         clk_oe_q  <= clk_oe_n;
         data_oe_q <= data_oe_n;
         done_q    <= done_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_n     = bit_idx;
      byte_n    = byte_q;
      par_n     = par_q;
      clk_oe_n  = clk_oe_q;
      data_oe_n = data_oe_q;
      done_n    = 1'b0;
      err_n     = 1'b0;

      case (state)
         S_IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (tx_valid) begin
               byte_n    = tx_data;
               par_n     = ~^tx_data;
               cnt_n     = '0;
               bit_n     = '0;
               clk_oe_n  = 1'b1;
               data_oe_n = (INHIBIT_CYCLES == 1);
               state_n   = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            clk_oe_n = 1'b1;
            if (cnt == INH_LAST) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
               cnt_n     = '0;
               state_n   = S_REQ;
            end else begin
               cnt_n = cnt + 1'b1;
               // Start bit goes low one cycle before the clock is released.
               if (cnt == INH_PRE) data_oe_n = 1'b1;
            end
         end

         S_REQ: begin
            if (fall) begin
               data_oe_n = ~byte_q[0];
               bit_n     = '0;
               state_n   = S_XFER;
            end
         end

         S_XFER: begin
            if (fall) begin
               if (bit_idx < 4'd7) begin
                  bit_n     = bit_idx + 4'd1;
                  data_oe_n = ~byte_q[bit_n[2:0]];
               end else if (bit_idx == 4'd7) begin
                  bit_n     = 4'd8;
                  data_oe_n = ~par_q;
               end else begin
                  data_oe_n = 1'b0;
                  state_n   = S_ACK;
               end
            end
         end

         S_ACK: begin
            if (fall) begin
               if (!data_s) begin
                  state_n = S_WAIT_IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end
            end
         end

         S_WAIT_IDLE: begin
            if (clk_s && data_s) begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
         end

         default: state_n = S_IDLE;
      endcase

      // Watchdog between device clock falls; a completed transfer takes precedence.
      if (state == S_REQ || state == S_XFER || state == S_ACK || state == S_WAIT_IDLE) begin
         if (fall) begin
            cnt_n = '0;
         end else if (cnt == TO_LAST && !done_n) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            err_n     = 1'b1;
            state_n   = S_IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
      end
   end

   assign tx_ready    = (state == S_IDLE);
   assign tx_done     = done_q;
   assign tx_err      = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_xps2_tx.sv
// Directed bench for xps2_tx: a behavioural PS/2 device clocks bits out of the
// host and the observed frames, pulses and line releases are checked.
module tb_xps2_tx;

   localparam int INH = 10;
   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic [2:0] state_dbg;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   logic [10:0] exp_q[$];

   // Open-drain bus: either side may pull a line low.
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   xps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done && tx_err) both_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] d, output int hi, output logic first_doe,
                            output logic last_doe);
      int t = 0;
      while (!tx_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid  = 1'b0;
      tx_data   = ~d;
      hi        = 0;
      first_doe = ps2_data_oe;
      last_doe  = 1'b0;
      while (ps2_clk_oe && hi < 100) begin
         last_doe = ps2_data_oe;
         hi++;
         @(negedge clk);
      end
   endtask

   // Device samples the data line late in each high phase, then drives a fall.
   task automatic run_device(input int nfalls, input bit ack, output logic [10:0] bits);
      bits = '0;
      for (int i = 0; i < nfalls; i++) begin
         repeat (15) @(negedge clk);
         bits = {ps2_data_in, bits[10:1]};
         if (i == 10 && ack) dev_data = 1'b0;
         repeat (5) @(negedge clk);
         dev_clk = 1'b0;
         repeat (20) @(negedge clk);
         dev_clk = 1'b1;
      end
      repeat (3) @(negedge clk);
      dev_data = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
      checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
      checks++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
      checks++; if (tx_done !== 1'b0 || tx_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", tx_done, tx_err); end
      checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      rst = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_send(input logic [7:0] d, input logic [10:0] frame, input string tag);
      int hi, d0, e0;
      logic fd, ld;
      logic [10:0] bits, exp;
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back(frame);
      send_byte(d, hi, fd, ld);
      checks++; if (hi != INH) begin failures++; $display("FAIL %s_inhibit_len: got %0d expected %0d", tag, hi, INH); end
      checks++; if (fd !== 1'b0) begin failures++; $display("FAIL %s_inhibit_first_data: got %b expected 0", tag, fd); end
      checks++; if (ld !== 1'b1) begin failures++; $display("FAIL %s_inhibit_last_data: got %b expected 1", tag, ld); end
      checks++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL %s_req_start: got %b expected 1", tag, ps2_data_oe); end
      run_device(11, 1'b1, bits);
      repeat (5) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bits !== exp) begin failures++; $display("FAIL %s_frame: got %h expected %h", tag, bits, exp); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done: got %0d expected 1", tag, done_cnt - d0); end
      checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL %s_err: got %0d expected 0", tag, err_cnt - e0); end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL %s_ready: got %b expected 1", tag, tx_ready); end
   endtask

   task automatic test_no_ack();
      int hi, d0, e0;
      logic fd, ld;
      logic [10:0] bits, exp;
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back({1'b1, 1'b1, 8'h00, 1'b0});
      send_byte(8'h00, hi, fd, ld);
      run_device(11, 1'b0, bits);
      repeat (5) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bits !== exp) begin failures++; $display("FAIL noack_frame: got %h expected %h", bits, exp); end
      checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL noack_err: got %0d expected 1", err_cnt - e0); end
      checks++; if (done_cnt - d0 != 0) begin failures++; $display("FAIL noack_done: got %0d expected 0", done_cnt - d0); end
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin failures++; $display("FAIL noack_release: got clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
   endtask

   task automatic test_timeout();
      int hi, d0, e0, t;
      logic fd, ld;
      logic [10:0] bits;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hED, hi, fd, ld);
      run_device(3, 1'b1, bits);
      repeat (20) @(negedge clk);
      dev_clk = 1'b0;
      t = 0;
      while (!tx_err && t < 1000) begin
         @(negedge clk);
         t++;
         if (t == 20) dev_clk = 1'b1;
      end
      // Pin fall + 3 cycles to detection, then TMO cycles to the abort.
      checks++; if (t != TMO + 3) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", t, TMO + 3); end
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin failures++; $display("FAIL timeout_release: got clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
      repeat (5) @(negedge clk);
      checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin failures++; $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0); end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready: got %b expected 1", tx_ready); end
   endtask

   task automatic test_ignore_busy();
      int hi, d0, e0, oe_seen;
      logic fd, ld, rdy_seen;
      logic [10:0] bits, exp;
      d0 = done_cnt;
      e0 = err_cnt;
      rdy_seen = 1'b1;
      exp_q.push_back({1'b1, 1'b1, 8'hAA, 1'b0});
      send_byte(8'hAA, hi, fd, ld);
      fork
         run_device(11, 1'b1, bits);
         begin
            repeat (100) @(negedge clk);
            rdy_seen = tx_ready;
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            repeat (60) @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (rdy_seen !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b expected 0", rdy_seen); end
      checks++; if (bits !== exp) begin failures++; $display("FAIL busy_frame: got %h expected %h", bits, exp); end
      checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin failures++; $display("FAIL busy_pulses: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0); end
      oe_seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ps2_clk_oe) oe_seen++;
      end
      checks++; if (oe_seen != 0) begin failures++; $display("FAIL busy_not_queued: got %0d clk_oe cycles expected 0", oe_seen); end
   endtask

   task automatic test_reset_mid();
      int hi, d0, e0;
      logic fd, ld;
      logic [10:0] bits;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hED, hi, fd, ld);
      run_device(5, 1'b1, bits);
      repeat (20) @(negedge clk);
      // Bit 4 of 0xED is 0, so the host is pulling data low here.
      checks++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL midrst_pre_data: got %b expected 1", ps2_data_oe); end
      dev_clk = 1'b0;
      rst     = 1'b0;
      #1;
      checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin failures++; $display("FAIL midrst_release: got clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
      repeat (3) @(negedge clk);
      dev_clk = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin failures++; $display("FAIL midrst_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0); end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", tx_ready); end
      test_send(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, "after_rst");
   endtask

   initial begin
      test_reset();
      test_send(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, "ed");
      test_send(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, "f4");
      test_no_ack();
      test_timeout();
      test_ignore_busy();
      test_reset_mid();
      checks++; if (both_cnt != 0) begin failures++; $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
